multdiv_seq: RTL and testbench



---
 rtl/multdiv_seq_pkg.sv | 28 ++
 rtl/addmodule_all32.sv | 29 ++
 rtl/multdiv_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_multdiv_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_seq_pkg.sv
// ============================================================================
// Module   : multdiv_seq_pkg
// Purpose  : State encodings and shared constants for the multiply/divide
//            sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multdiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int          MD_ITER_COUNT = 32;
    localparam logic [4:0]  MD_ITER_LAST  = 5'(MD_ITER_COUNT - 1);
    localparam logic        MD_OP_MULT    = 1'b0;
    localparam logic        MD_OP_DIV     = 1'b1;
    localparam logic [31:0] MD_MIN_NEG    = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/addmodule_all32.sv
// ============================================================================
// Module   : addmodule_all32
// Purpose  : 32-bit ripple-carry adder with carry in and carry out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addmodule_all32 (
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]       = in_a[i] ^ in_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (in_a[i] & in_b[i]) | (w_carry[i] & (in_a[i] ^ in_b[i]));
    end

    assign cout = w_carry[32];

endmodule

`default_nettype wire

// File: rtl/multdiv_seq.sv
// ============================================================================
// Module   : multdiv_seq
// Purpose  : Fixed-latency (36 cycle) signed 32-bit shift-add multiply and
//            restoring divide, all arithmetic on one shared ripple adder.
//            Divide support is built only when MULTDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    import multdiv_seq_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [32:0] r_h;
    logic [31:0] r_l;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    logic        w_start;
    logic        w_op;
    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_cin;
    logic [31:0] w_sum;
    logic        w_cout;
    logic [32:0] w_mul_h;
    logic        w_prod_nz;
    logic        w_neg;
    logic [31:0] w_fix_res;
    logic        w_fix_exc;

`ifdef MULTDIV_DIV_EN
    logic [31:0] w_t_r;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_op    = ctrl_MULT ? MD_OP_MULT : MD_OP_DIV;
    assign w_t_r   = {r_h[30:0], r_l[31]};
`else
    localparam logic C_DIV_BUILD = 1'b0;

    assign w_start = ctrl_MULT | (ctrl_DIV & C_DIV_BUILD);
    assign w_op    = MD_OP_MULT;
`endif

    addmodule_all32 u_add (
        .in_a (w_add_a),
        .in_b (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Adder operand steering: negations use ~x + 1 with the carry-in.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_NEG_A: begin
                w_add_a   = ~r_a;
                w_add_cin = 1'b1;
            end
            ST_NEG_B: begin
                w_add_a   = ~r_b;
                w_add_cin = 1'b1;
            end
            ST_ITER: begin
`ifdef MULTDIV_DIV_EN
                if (r_op == MD_OP_DIV) begin
                    w_add_a   = w_t_r;
                    w_add_b   = ~r_b;
                    w_add_cin = 1'b1;
                end else
`endif
                begin
                    w_add_a = r_h[31:0];
                    w_add_b = r_a;
                end
            end
            ST_FIX: begin
                w_add_a   = ~r_l;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_mul_h   = r_l[0] ? {w_cout, w_sum} : r_h;
    assign w_prod_nz = |{r_h, r_l};
    assign w_neg     = (r_sign_a ^ r_sign_b) & ((r_op == MD_OP_DIV) | w_prod_nz);

    // The magnitude sits in r_l for both ops (product low word or quotient).
    always_comb begin
        w_fix_res = w_neg ? w_sum : r_l;
        w_fix_exc = (|r_h) | (w_neg ? (r_l > MD_MIN_NEG) : (r_l >= MD_MIN_NEG));
`ifdef MULTDIV_DIV_EN
        if (r_op == MD_OP_DIV) begin
            if (~|r_b) begin
                w_fix_res = '0;
                w_fix_exc = 1'b1;
            end else begin
                w_fix_exc = ~w_neg & (r_l >= MD_MIN_NEG);
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = ST_NEG_A;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_IDLE;
                ST_NEG_A: w_next = ST_NEG_B;
                ST_NEG_B: w_next = ST_ITER;
                ST_ITER:  w_next = (r_cnt == MD_ITER_LAST) ? ST_FIX : ST_ITER;
                ST_FIX:   w_next = ST_DONE;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= MD_OP_MULT;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_a      <= data_operandA;
                r_b      <= data_operandB;
                r_sign_a <= data_operandA[31];
                r_sign_b <= data_operandB[31];
                r_op     <= w_op;
                r_result <= '0;
                r_exc    <= 1'b0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    ST_NEG_A: begin
                        if (r_sign_a) r_a <= w_sum;
                    end
                    ST_NEG_B: begin
                        r_h <= '0;
                        if (r_sign_b) r_b <= w_sum;
`ifdef MULTDIV_DIV_EN
                        if (r_op == MD_OP_DIV) r_l <= r_a;
                        else
`endif
                        r_l <= r_sign_b ? w_sum : r_b;
                    end
                    ST_ITER: begin
                        r_cnt <= r_cnt + 5'd1;
`ifdef MULTDIV_DIV_EN
                        // Restoring step: carry out means T_R >= |B|.
                        if (r_op == MD_OP_DIV) begin
                            r_h <= {1'b0, (w_cout ? w_sum : w_t_r)};
                            r_l <= {r_l[30:0], w_cout};
                        end else
`endif
                        begin
                            r_h <= {1'b0, w_mul_h[32:1]};
                            r_l <= {w_mul_h[0], r_l[31:1]};
                        end
                    end
                    ST_FIX: begin
                        r_result <= w_fix_res;
                        r_exc    <= w_fix_exc;
                        r_rdy    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_seq.sv
// ============================================================================
// Module   : tb_multdiv_seq
// Purpose  : Self-checking bench for multdiv_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic with the divide corner cases.
    function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = a;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'($urandom);
        data_operandB = 32'($urandom);
    endtask

    // Observes a fixed window; cycle 1 is the negedge right after the start edge.
    task automatic watch(input int limit, output int first, output int npulse, output bit busy_ok,
                         output bit busy_any, output logic [31:0] res, output logic exc);
        first = 0; npulse = 0; busy_ok = 1'b1; busy_any = 1'b0; res = '0; exc = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            if (i > 1) @(negedge clock);
            if (busy) busy_any = 1'b1;
            if (data_resultRDY) begin
                npulse++;
                if (first == 0) begin
                    first = i;
                    res   = data_result;
                    exc   = data_exception;
                end
            end
            if ((first == 0 || first == i) && !busy) busy_ok = 1'b0;
            if (first != 0 && first < i && busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b);
        int first, n;
        bit ok, any;
        logic [31:0] res, er;
        logic exc, ee, is_div, active;
        is_div = !m && d && DIV_EN;
        active = m || is_div;
        model(is_div, a, b, er, ee);
        pulse(m, d, a, b);
        watch(40, first, n, ok, any, res, exc);
        if (active) begin
            check({tag, " latency"}, 64'(first), 64'd36);
            check({tag, " pulses"}, 64'(n), 64'd1);
            check({tag, " busy"}, 64'(ok), 64'd1);
            check({tag, " result"}, 64'(res), 64'(er));
            check({tag, " exception"}, 64'(exc), 64'(ee));
            check({tag, " hold"}, 64'(data_result), 64'(er));
        end else begin
            check({tag, " ignored pulses"}, 64'(n), 64'd0);
            check({tag, " ignored busy"}, 64'(any), 64'd0);
        end
    endtask

    task automatic abort_op(input string tag, input logic d2, input logic [31:0] a2, input logic [31:0] b2);
        int first, n;
        bit ok, any;
        logic [31:0] res, er;
        logic exc, ee, live;
        live = !d2 || DIV_EN;
        pulse(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) @(negedge clock);
        pulse(!d2, d2, a2, b2);
        watch(40, first, n, ok, any, res, exc);
        if (live) model(d2, a2, b2, er, ee);
        else      model(1'b0, 32'd3, 32'd4, er, ee);
        check({tag, " latency"}, 64'(first), live ? 64'd36 : 64'd26);
        check({tag, " pulses"}, 64'(n), 64'd1);
        check({tag, " result"}, 64'(res), 64'(er));
        check({tag, " exception"}, 64'(exc), 64'(ee));
    endtask

    initial begin
        int first, n;
        bit ok, any;
        logic [31:0] res;
        logic exc, m, d;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'd0);
        reset = 1'b0;

        run_op("mul 7x-6",        1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        run_op("mul 2^16x2^16",   1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op("mul min x 1",     1'b1, 1'b0, 32'h8000_0000, 32'd1);
        run_op("div -7/2",        1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div 5/0",         1'b0, 1'b1, 32'd5, 32'd0);
        run_op("div min/-1",      1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("both 6,3",        1'b1, 1'b1, 32'd6, 32'd3);

        abort_op("abort by div", 1'b1, 32'd100, 32'd7);
        abort_op("abort by mul", 1'b0, 32'd5, 32'd6);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       begin m = 1'b1; d = 1'b1; end
                1:       begin m = 1'b0; d = 1'b1; end
                default: begin m = 1'b1; d = 1'b0; end
            endcase
            run_op($sformatf("rand%0d", k), m, d, rnd_operand(), rnd_operand());
        end

        // Reset must clear a held nonzero result and exception.
        run_op("mul pre-reset", 1'b1, 1'b0, 32'h0001_0001, 32'h0001_0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset clears held", 64'({data_result, data_exception}), 64'd0);

        // Reset mid-operation discards the op.
        pulse(!DIV_EN, DIV_EN, 32'd100, 32'd7);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid reset outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'd0);
        watch(40, first, n, ok, any, res, exc);
        check("mid reset no ready", 64'(n), 64'd0);
        check("mid reset idle", 64'(any), 64'd0);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        check("reset priority busy", 64'(busy), 64'd0);
        watch(40, first, n, ok, any, res, exc);
        check("reset priority no ready", 64'(n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
